// File: rtl/debouncer_multi.sv
// Multi-channel push-button debouncer: per-channel synchroniser, stability-window
// filter, registered press/release pulses and an optional hold-to-auto-repeat FSM.
module debouncer_multi #(
    parameter int NUM_CH       = 5,
    parameter int NUM_TICKS    = 12500,
    parameter int ACTIVE_LOW   = 0,
    parameter int REPEAT_EN    = 1,
    parameter int HOLD_TICKS   = 6250000,
    parameter int REPEAT_TICKS = 1250000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic [NUM_CH-1:0] btn_repeat
);

    localparam int FILT_W  = $clog2(NUM_TICKS + 1);
    localparam int RPT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [FILT_W-1:0] FILT_TERM = FILT_W'(NUM_TICKS - 1);
    localparam logic [RPT_W-1:0]  HOLD_TERM = RPT_W'(HOLD_TICKS - 1);
    localparam logic [RPT_W-1:0]  REP_TERM  = RPT_W'(REPEAT_TICKS - 1);
    localparam logic              IDLE_RAW  = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic              s1_q;
            logic              s2_q;
            logic              sample;
            logic [FILT_W-1:0] filt_cnt_q;
            logic [FILT_W-1:0] filt_cnt_d;
            logic              level_q;
            logic              level_d;
            logic              press_q;
            logic              release_q;
            logic              rise;
            logic              fall;

            assign sample = s2_q ^ IDLE_RAW;

            // Any sample agreeing with the current level restarts the window.
            always_comb begin
                filt_cnt_d = filt_cnt_q;
                level_d    = level_q;
                if (sample == level_q) begin
                    filt_cnt_d = '0;
                end else if (filt_cnt_q == FILT_TERM) begin
                    level_d    = sample;
                    filt_cnt_d = '0;
                end else begin
                    filt_cnt_d = filt_cnt_q + 1'b1;
                end
            end

            assign rise = level_d & ~level_q;
            assign fall = ~level_d & level_q;

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    s1_q       <= IDLE_RAW;
                    s2_q       <= IDLE_RAW;
                    filt_cnt_q <= '0;
                    level_q    <= 1'b0;
                    press_q    <= 1'b0;
                    release_q  <= 1'b0;
                end else begin
                    s1_q       <= btn_in[gi];
                    s2_q       <= s1_q;
                    filt_cnt_q <= filt_cnt_d;
                    level_q    <= level_d;
                    press_q    <= rise;
                    release_q  <= fall;
                end
            end

            assign btn_level[gi]   = level_q;
            assign btn_press[gi]   = press_q;
            assign btn_release[gi] = release_q;

            if (REPEAT_EN != 0) begin : g_rpt
                rpt_state_t       state_q;
                logic [RPT_W-1:0] rpt_cnt_q;
                logic             repeat_q;

                // A release on the same edge as a due repeat suppresses that repeat.
                always_ff @(posedge Clock) begin
                    if (Reset) begin
                        state_q   <= ST_IDLE;
                        rpt_cnt_q <= '0;
                        repeat_q  <= 1'b0;
                    end else begin
                        repeat_q <= 1'b0;
                        if (fall) begin
                            state_q   <= ST_IDLE;
                            rpt_cnt_q <= '0;
                        end else begin
                            case (state_q)
                                ST_IDLE: begin
                                    if (rise) begin
                                        state_q   <= ST_HOLD;
                                        rpt_cnt_q <= '0;
                                    end
                                end
                                ST_HOLD: begin
                                    if (rpt_cnt_q == HOLD_TERM) begin
                                        repeat_q  <= 1'b1;
                                        state_q   <= ST_REPEAT;
                                        rpt_cnt_q <= '0;
                                    end else begin
                                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                                    end
                                end
                                ST_REPEAT: begin
                                    if (rpt_cnt_q == REP_TERM) begin
                                        repeat_q  <= 1'b1;
                                        rpt_cnt_q <= '0;
                                    end else begin
                                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                                    end
                                end
                                default: begin
                                    state_q   <= ST_IDLE;
                                    rpt_cnt_q <= '0;
                                end
                            endcase
                        end
                    end
                end

                assign btn_repeat[gi] = repeat_q;
            end else begin : g_no_rpt
                assign btn_repeat[gi] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: NUM_CH=2, NUM_TICKS=4, HOLD_TICKS=10,
// REPEAT_TICKS=3, with an active-high instance and an idle-high (ACTIVE_LOW=1) instance.
module tb_debouncer_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_in;
    logic [1:0] btn_level, btn_press, btn_release, btn_repeat;
    logic [1:0] al_in;
    logic [1:0] al_level, al_press, al_release, al_repeat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debouncer_multi #(
        .NUM_CH(2), .NUM_TICKS(4), .ACTIVE_LOW(0), .REPEAT_EN(1),
        .HOLD_TICKS(10), .REPEAT_TICKS(3)
    ) dut (
        .Clock(clk), .Reset(rst), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    debouncer_multi #(
        .NUM_CH(2), .NUM_TICKS(4), .ACTIVE_LOW(1), .REPEAT_EN(1),
        .HOLD_TICKS(10), .REPEAT_TICKS(3)
    ) dut_al (
        .Clock(clk), .Reset(rst), .btn_in(al_in),
        .btn_level(al_level), .btn_press(al_press),
        .btn_release(al_release), .btn_repeat(al_repeat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk_al_idle(input string tag);
        chk(tag, {24'd0, al_level, al_press, al_release, al_repeat}, 32'd0);
    endtask

    initial begin
        logic bounce [8];
        bounce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rst    = 1'b1;
        btn_in = 2'b00;
        al_in  = 2'b11;
        ticks(2);
        rst = 1'b0;
        chk("rst_outputs", {24'd0, btn_level, btn_press, btn_release, btn_repeat}, 32'd0);
        chk_al_idle("rst_al_outputs");
        ticks(3);

        // 1: clean press, level and press at edge 5, release at edge 12
        $display("scenario 1: clean press/release on channel 0");
        btn_in[0] = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            if (e == 7) btn_in[0] = 1'b0;
            tick();
            chk("s1_press0",   btn_press[0],   e == 5);
            chk("s1_level0",   btn_level[0],   e >= 5 && e < 12);
            chk("s1_release0", btn_release[0], e == 12);
            chk("s1_repeat0",  btn_repeat[0],  0);
            chk("s1_ch1", {btn_level[1], btn_press[1], btn_release[1], btn_repeat[1]}, 0);
            chk_al_idle("s1_al_idle");
        end
        ticks(3);

        // 2: bounce 1,1,1,0,1,1,1,1 -> last rising step captured at edge 4, press at 9
        $display("scenario 2: bounce restarts the window");
        for (int e = 0; e <= 10; e++) begin
            btn_in[0] = (e < 8) ? bounce[e] : 1'b1;
            tick();
            chk("s2_press0", btn_press[0], e == 9);
            chk("s2_level0", btn_level[0], e >= 9);
        end
        btn_in[0] = 1'b0;
        ticks(8);

        // 3: press at 5, repeats at 15..33 step 3, release at 34
        $display("scenario 3: hold and auto-repeat");
        btn_in[0] = 1'b1;
        for (int e = 0; e <= 45; e++) begin
            if (e == 29) btn_in[0] = 1'b0;
            tick();
            chk("s3_repeat0",  btn_repeat[0],  e >= 15 && e <= 33 && ((e - 15) % 3) == 0);
            chk("s3_release0", btn_release[0], e == 34);
            chk("s3_press0",   btn_press[0],   e == 5);
            chk("s3_level0",   btn_level[0],   e >= 5 && e < 34);
        end
        ticks(3);

        // 4: level falls at 21 where a repeat is due; re-press at 35 repeats at 45
        $display("scenario 4: release beats a due repeat, re-press restarts hold");
        btn_in[0] = 1'b1;
        for (int e = 0; e <= 46; e++) begin
            if (e == 16) btn_in[0] = 1'b0;
            if (e == 30) btn_in[0] = 1'b1;
            tick();
            chk("s4_repeat0",  btn_repeat[0],  e == 15 || e == 18 || e == 45);
            chk("s4_release0", btn_release[0], e == 21);
            chk("s4_press0",   btn_press[0],   e == 5 || e == 35);
        end
        btn_in[0] = 1'b0;
        ticks(8);

        // 5: both pressed, channel 1 drops at edge 2; it then needs a full fresh window
        $display("scenario 5: simultaneous press, channel 1 aborted");
        btn_in = 2'b11;
        for (int e = 0; e <= 8; e++) begin
            if (e == 2) btn_in[1] = 1'b0;
            tick();
            chk("s5_press0", btn_press[0], e == 5);
            chk("s5_press1", btn_press[1], 0);
            chk("s5_level1", btn_level[1], 0);
        end
        btn_in[1] = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk("s5_repress1", btn_press[1], e == 5);
        end
        btn_in = 2'b00;
        ticks(8);

        // 6: reset while in REPEAT with input held high
        $display("scenario 6: reset during auto-repeat");
        btn_in = 2'b01;
        ticks(20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_rst_outputs", {24'd0, btn_level, btn_press, btn_release, btn_repeat}, 32'd0);
        chk_al_idle("s6_rst_al");
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk("s6_press0",  btn_press[0],  e == 5);
            chk("s6_level0",  btn_level[0],  e >= 5);
            chk("s6_repeat0", btn_repeat[0], 0);
            chk_al_idle("s6_al_idle");
        end

        // Active-low instance: pulling channel 1 low is a press
        $display("scenario 7: active-low press");
        al_in[1] = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk("s7_al_press1", al_press[1], e == 5);
            chk("s7_al_level1", al_level[1], e >= 5);
            chk("s7_al_ch0",    {al_level[0], al_press[0]}, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
